// File: rtl/cordic_pkg.sv
// Shared types and fixed-point constants for the iterative rotation CORDIC.
// Constants are kept at high precision and rescaled to the datapath widths at elaboration.
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // CORDIC gain compensation 1/An for many iterations, Q1.30
  localparam longint CORDIC_K_Q = 64'sd652032874;
  localparam int     K_FRAC     = 30;

  // Angle constants, Q3.29
  localparam longint PI         = 64'sd1686629713;
  localparam longint HALF_PI    = 64'sd843314857;
  localparam int     ANGLE_FRAC = 29;

  localparam int     ATAN_FRAC  = 30;

  function automatic longint rescale(input longint v, input int from_frac, input int to_frac);
    if (to_frac >= from_frac) return v <<< (to_frac - from_frac);
    return (v + (64'sd1 <<< (from_frac - to_frac - 1))) >>> (from_frac - to_frac);
  endfunction

  // atan(2^-i) rounded to 'frac' fractional bits; beyond i=10 atan(2^-i) equals 2^-i at Q1.30
  function automatic longint ATAN_TABLE(input int i, input int frac);
    longint q30;
    case (i)
      0:       q30 = 64'sd843314857;
      1:       q30 = 64'sd497837830;
      2:       q30 = 64'sd263043837;
      3:       q30 = 64'sd133525159;
      4:       q30 = 64'sd67021687;
      5:       q30 = 64'sd33543516;
      6:       q30 = 64'sd16775851;
      7:       q30 = 64'sd8388437;
      8:       q30 = 64'sd4194283;
      9:       q30 = 64'sd2097149;
      10:      q30 = 64'sd1048576;
      default: q30 = (i > 10 && i <= 30) ? (64'sd1 <<< (30 - i)) : 64'sd0;
    endcase
    return rescale(q30, ATAN_FRAC, frac);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: micro-rotation index -> atan(2^-idx) in the z-datapath format.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GUARD = 2,
  parameter int ITERS = 16,
  localparam int IW = $clog2(ITERS + 2),
  localparam int ZW = WIDTH + GUARD
) (
  input  logic [IW-1:0]        idx,
  output logic signed [ZW-1:0] atan_val
);

  always_comb begin
    atan_val = ZW'(ATAN_TABLE(int'(idx), WIDTH - 3 + GUARD));
  end

endmodule

// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: one angle in, cos/sin out after ITERS micro-rotations plus a rounding cycle.
// Define CORDIC_QUAD_EXT_EN to accept the full +/-pi range via a quadrant pre-rotation cycle.
module cordic_rot_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 16,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] angle_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out,
  output logic             busy
);

  localparam int XW = WIDTH + GUARD + 1;
  localparam int XF = WIDTH - 2 + GUARD;
  localparam int ZW = WIDTH + GUARD;
  localparam int ZF = WIDTH - 3 + GUARD;
  localparam int AF = WIDTH - 3;
  localparam int RW = XW + 1;
  localparam int CW = $clog2(ITERS + 2);

`ifdef CORDIC_QUAD_EXT_EN
  localparam int STEP_OFS = 1;
  localparam longint ANGLE_MAX = PI;
  localparam logic signed [ZW-1:0] PI_Z      = ZW'(rescale(PI, ANGLE_FRAC, ZF));
  localparam logic signed [ZW-1:0] HALF_PI_Z = ZW'(rescale(HALF_PI, ANGLE_FRAC, ZF));
`else
  localparam int STEP_OFS = 0;
  localparam longint ANGLE_MAX = HALF_PI;
`endif

  localparam logic [CW-1:0]          FINAL_CNT = CW'(ITERS + STEP_OFS);
  localparam logic signed [WIDTH-1:0] ANG_LIM  = WIDTH'(rescale(ANGLE_MAX, ANGLE_FRAC, AF));
  localparam logic signed [XW-1:0]   K_X       = XW'(rescale(CORDIC_K_Q, K_FRAC, XF));
  localparam logic signed [RW-1:0]   RND_HALF  = RW'((64'sd1 <<< GUARD) >>> 1);
  localparam logic signed [RW-1:0]   SAT_MAX   = RW'((64'sd1 <<< (WIDTH - 1)) - 1);

  state_t state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic signed [XW-1:0]   x_q, y_q;
  logic signed [ZW-1:0]   z_q;
  logic                   neg_q;
  logic [WIDTH-1:0]       cos_q, sin_q;

  logic signed [WIDTH-1:0] angle_sat;
  logic [CW-1:0]           step_idx;
  logic signed [ZW-1:0]    atan_val;
  logic signed [XW-1:0]    x_sh, y_sh;
  logic                    z_pos;

  // Symmetric saturation keeps -2^(WIDTH-1) out of the result range
  function automatic logic [WIDTH-1:0] round_sat(input logic signed [XW-1:0] v, input logic neg);
    logic signed [RW-1:0] t;
    t = neg ? -RW'(v) : RW'(v);
    t = (t + RND_HALF) >>> GUARD;
    if (t > SAT_MAX) t = SAT_MAX;
    else if (t < -SAT_MAX) t = -SAT_MAX;
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    angle_sat = $signed(angle_in);
    if ($signed(angle_in) > ANG_LIM) angle_sat = ANG_LIM;
    else if ($signed(angle_in) < -ANG_LIM) angle_sat = -ANG_LIM;
  end

  assign step_idx = cnt_q - CW'(STEP_OFS);
  assign x_sh     = x_q >>> step_idx;
  assign y_sh     = y_q >>> step_idx;
  assign z_pos    = ~z_q[ZW-1];

  cordic_atan_rom #(
    .WIDTH(WIDTH),
    .GUARD(GUARD),
    .ITERS(ITERS)
  ) u_atan_rom (
    .idx     (step_idx),
    .atan_val(atan_val)
  );

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == FINAL_CNT) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final RUN cycle rounds into the output registers, which then hold through DONE
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      neg_q <= 1'b0;
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q   <= K_X;
            y_q   <= '0;
            z_q   <= ZW'(angle_sat) <<< GUARD;
            cnt_q <= '0;
            neg_q <= 1'b0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == FINAL_CNT) begin
            cos_q <= round_sat(x_q, neg_q);
            sin_q <= round_sat(y_q, neg_q);
          end
`ifdef CORDIC_QUAD_EXT_EN
          else if (cnt_q == '0) begin
            if (z_q > HALF_PI_Z) begin
              z_q   <= z_q - PI_Z;
              neg_q <= 1'b1;
            end else if (z_q < -HALF_PI_Z) begin
              z_q   <= z_q + PI_Z;
              neg_q <= 1'b1;
            end
          end
`endif
          else begin
            x_q <= z_pos ? (x_q - y_sh) : (x_q + y_sh);
            y_q <= z_pos ? (y_q + x_sh) : (y_q - x_sh);
            z_q <= z_pos ? (z_q - atan_val) : (z_q + atan_val);
          end
        end
        default: ;
      endcase
    end
  end

  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Scoreboard bench for cordic_rot_iter: real-valued cos/sin reference, latency, hold and reset-abort checks.
// Honours CORDIC_QUAD_EXT_EN for the accepted angle range and latency.
module tb_cordic_rot_iter;

`ifdef CORDIC_QUAD_EXT_EN
  localparam int ANG_LIM = 25736;
  localparam int LAT     = 18;
`else
  localparam int ANG_LIM = 12868;
  localparam int LAT     = 17;
`endif
  localparam int TOL = 4;

  typedef struct {
    int c;
    int s;
    int acc;
  } exp_t;

  logic        clk;
  logic        rst_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] angle_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] cos_out;
  logic [15:0] sin_out;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  cordic_rot_iter #(
    .WIDTH(16),
    .ITERS(16),
    .GUARD(2)
  ) dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .angle_in (angle_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cos_out  (cos_out),
    .sin_out  (sin_out),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  // Ideal trig of the clamped angle, scaled to Q2.14
  function automatic void ref_model(input int ang, output int c, output int s);
    int  a;
    real r;
    a = ang;
    if (a > ANG_LIM) a = ANG_LIM;
    else if (a < -ANG_LIM) a = -ANG_LIM;
    r = real'(a) / 8192.0;
    c = sat(rnd($cos(r) * 16384.0));
    s = sat(rnd($sin(r) * 16384.0));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    int diff;
    checks++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, actual, expected, tol, cyc);
    end
  endtask

  // Waits for IDLE, accepts one angle, and records what the result must be
  task automatic applyStimulus(input int ang);
    int   n;
    exp_t e;
    n = 0;
    in_valid = 1'b1;
    angle_in = 16'(ang);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    ref_model(ang, e.c, e.s);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    angle_in = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: pending=%0d out_valid=%0b, expected 0/0", exp_q.size(), out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented result is compared with the front of the scoreboard, popped on handshake
  initial begin
    bit prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_in) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: out_valid=1 cos=%0d, expected no result", $signed(cos_out));
          end else begin
            if (!prev_valid) checkOutput("latency", cyc - exp_q[0].acc, LAT, 0);
            checkOutput("cos", int'($signed(cos_out)), exp_q[0].c, TOL);
            checkOutput("sin", int'($signed(sin_out)), exp_q[0].s, TOL);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_valid = out_valid && !out_ready;
      end
    end
  end

  initial begin
    int dir_angles[10] = '{0, 6434, -12868, 20000, -20000, 12868, 25736, -25736, 32767, -32768};
    int n;

    rst_in    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    angle_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 1, 0);
    checkOutput("reset_out_valid", int'(out_valid), 0, 0);
    checkOutput("reset_busy", int'(busy), 0, 0);
    checkOutput("reset_cos", int'($signed(cos_out)), 0, 0);
    checkOutput("reset_sin", int'($signed(sin_out)), 0, 0);
    rst_in = 1'b1;
    @(posedge clk);
    #1;

    foreach (dir_angles[i]) begin
      applyStimulus(dir_angles[i]);
      wait_idle();
    end

    // Result held under back-pressure while a second request is refused
    out_ready = 1'b0;
    applyStimulus(6434);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hold_reach_done", int'(out_valid), 1, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      angle_in = 16'(-6434);
      @(negedge clk);
      checkOutput("hold_in_ready", int'(in_ready), 0, 0);
      checkOutput("hold_out_valid", int'(out_valid), 1, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (LAT + 3) @(negedge clk);
    @(posedge clk);
    #1;

    // Abort in the middle of the micro-rotations
    applyStimulus(3000);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("run_busy", int'(busy), 1, 0);
    rst_in = 1'b0;
    #1;
    checkOutput("abort_out_valid", int'(out_valid), 0, 0);
    checkOutput("abort_cos", int'($signed(cos_out)), 0, 0);
    checkOutput("abort_sin", int'($signed(sin_out)), 0, 0);
    checkOutput("abort_in_ready", int'(in_ready), 1, 0);
    checkOutput("abort_busy", int'(busy), 0, 0);
    exp_q.delete();
    @(negedge clk);
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(-6434);
    wait_idle();

    // Back-to-back random angles over the full input range
    for (int k = 0; k < 24; k++) begin
      applyStimulus(int'($urandom_range(0, 65535)) - 32768);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
